// File: rtl/drift_apply_scheduler_if.sv
// Bundles used by drift_apply_scheduler: the clock-domain pair and the
// accumulator / preemptive-generator handshake. The scheduler is the slave side.
interface sys_dom_if;
    logic clk;
    logic sync_rst;

    modport master (output clk, output sync_rst);
    modport slave  (input  clk, input  sync_rst);
endinterface

interface drift_apply_scheduler_if;
    logic pos_drift_ready_i;
    logic neg_drift_ready_i;
    logic drift_accepted_o;
    logic preempt_ready_i;
    logic apply_pos_o;
    logic apply_neg_o;

    modport master (
        output pos_drift_ready_i, neg_drift_ready_i, preempt_ready_i,
        input  drift_accepted_o, apply_pos_o, apply_neg_o
    );
    modport slave (
        input  pos_drift_ready_i, neg_drift_ready_i, preempt_ready_i,
        output drift_accepted_o, apply_pos_o, apply_neg_o
    );
endinterface

// File: rtl/drift_apply_scheduler.sv
// Paces drift applications from the accumulator to the preemptive clock generator,
// enforcing a minimum edge holdoff and flagging too many drifts per edge window.
module drift_apply_scheduler #(
    parameter int unsigned EDGE_CNT_WIDTH = 8,
    parameter int unsigned WINDOW_WIDTH   = 8
) (
    sys_dom_if.slave                     sys_dom_i,
    input  logic                         sched_en_i,
    input  logic                         any_valid_edge_i,
    input  logic [EDGE_CNT_WIDTH-1:0]    min_edges_i,
    input  logic [WINDOW_WIDTH-1:0]      window_edges_i,
    input  logic [WINDOW_WIDTH-1:0]      max_drifts_i,
    drift_apply_scheduler_if.slave       drift_if,
    output logic                         holdoff_active_o,
    output logic                         freq_violation_o,
    input  logic                         violation_clear_i,
    output logic [WINDOW_WIDTH-1:0]      drifts_in_window_o
);

    typedef enum logic [1:0] {
        ST_DISABLED,
        ST_HOLDOFF,
        ST_ARMED,
        ST_APPLY
    } state_e;

    localparam logic [EDGE_CNT_WIDTH-1:0] EDGE_MAX = '1;
    localparam logic [WINDOW_WIDTH-1:0]   DRIFT_MAX = '1;

    state_e                    state_q, state_d;
    logic [EDGE_CNT_WIDTH-1:0] holdoff_cnt_q, holdoff_cnt_d;
    logic [WINDOW_WIDTH-1:0]   win_cnt_q, win_cnt_d;
    logic [WINDOW_WIDTH-1:0]   drift_cnt_q, drift_cnt_d;
    logic                      freq_violation_q, freq_violation_d;
    logic                      apply_pos_q, apply_pos_d;
    logic                      apply_neg_q, apply_neg_d;
    logic                      rollover;
    logic [WINDOW_WIDTH-1:0]   drift_post;

    always_comb begin
        state_d          = state_q;
        holdoff_cnt_d    = holdoff_cnt_q;
        win_cnt_d        = win_cnt_q;
        drift_cnt_d      = drift_cnt_q;
        freq_violation_d = freq_violation_q;
        apply_pos_d      = 1'b0;
        apply_neg_d      = 1'b0;

        rollover = (state_q != ST_DISABLED) && any_valid_edge_i &&
                   (win_cnt_q == window_edges_i - WINDOW_WIDTH'(1));
        // A drift landing on the rollover edge is the first of the new window.
        drift_post = rollover ? WINDOW_WIDTH'(1) :
                     (drift_cnt_q == DRIFT_MAX) ? drift_cnt_q : drift_cnt_q + WINDOW_WIDTH'(1);

        if (rollover) begin
            win_cnt_d = '0;
        end else if ((state_q != ST_DISABLED) && any_valid_edge_i) begin
            win_cnt_d = win_cnt_q + WINDOW_WIDTH'(1);
        end

        if (state_q == ST_APPLY) begin
            drift_cnt_d = drift_post;
        end else if (rollover) begin
            drift_cnt_d = '0;
        end

        if ((state_q == ST_APPLY) && (window_edges_i != '0) && (drift_post > max_drifts_i)) begin
            freq_violation_d = 1'b1;
        end else if (violation_clear_i) begin
            freq_violation_d = 1'b0;
        end

        case (state_q)
            ST_DISABLED: begin
                state_d = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                if (any_valid_edge_i && (holdoff_cnt_q != EDGE_MAX)) begin
                    holdoff_cnt_d = holdoff_cnt_q + EDGE_CNT_WIDTH'(1);
                end
                if (holdoff_cnt_q >= min_edges_i) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (drift_if.preempt_ready_i &&
                    (drift_if.pos_drift_ready_i ^ drift_if.neg_drift_ready_i)) begin
                    state_d     = ST_APPLY;
                    apply_pos_d = drift_if.pos_drift_ready_i;
                    apply_neg_d = drift_if.neg_drift_ready_i;
                end
            end
            ST_APPLY: begin
                state_d       = ST_HOLDOFF;
                holdoff_cnt_d = any_valid_edge_i ? EDGE_CNT_WIDTH'(1) : '0;
            end
            default: begin
                state_d = ST_DISABLED;
            end
        endcase

        // Disable overrides everything except the sticky violation flag.
        if (!sched_en_i) begin
            state_d       = ST_DISABLED;
            holdoff_cnt_d = '0;
            win_cnt_d     = '0;
            drift_cnt_d   = '0;
            apply_pos_d   = 1'b0;
            apply_neg_d   = 1'b0;
        end
    end

    always_ff @(posedge sys_dom_i.clk) begin
        if (sys_dom_i.sync_rst) begin
            state_q          <= ST_DISABLED;
            holdoff_cnt_q    <= '0;
            win_cnt_q        <= '0;
            drift_cnt_q      <= '0;
            freq_violation_q <= 1'b0;
            apply_pos_q      <= 1'b0;
            apply_neg_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            holdoff_cnt_q    <= holdoff_cnt_d;
            win_cnt_q        <= win_cnt_d;
            drift_cnt_q      <= drift_cnt_d;
            freq_violation_q <= freq_violation_d;
            apply_pos_q      <= apply_pos_d;
            apply_neg_q      <= apply_neg_d;
        end
    end

    assign drift_if.apply_pos_o      = apply_pos_q;
    assign drift_if.apply_neg_o      = apply_neg_q;
    assign drift_if.drift_accepted_o = apply_pos_q | apply_neg_q;
    assign holdoff_active_o          = (state_q == ST_HOLDOFF);
    assign freq_violation_o          = freq_violation_q;
    assign drifts_in_window_o        = drift_cnt_q;

endmodule

// File: tb/tb_drift_apply_scheduler.sv
// Self-checking bench for drift_apply_scheduler: directed table, corner sequences,
// and randomized traffic against a behavioural model.
module tb_drift_apply_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, edg, pos, neg, prdy, clr;
    logic [7:0] min_e, win_e, max_d;
    logic       hold, viol;
    logic [7:0] drifts;

    int checks = 0;
    int errors = 0;

    sys_dom_if               sys_dom ();
    drift_apply_scheduler_if drift_if ();

    assign sys_dom.clk                = clk;
    assign sys_dom.sync_rst           = rst;
    assign drift_if.pos_drift_ready_i = pos;
    assign drift_if.neg_drift_ready_i = neg;
    assign drift_if.preempt_ready_i   = prdy;

    always #5 clk = ~clk;

    drift_apply_scheduler #(
        .EDGE_CNT_WIDTH (8),
        .WINDOW_WIDTH   (8)
    ) dut (
        .sys_dom_i          (sys_dom),
        .sched_en_i         (en),
        .any_valid_edge_i   (edg),
        .min_edges_i        (min_e),
        .window_edges_i     (win_e),
        .max_drifts_i       (max_d),
        .drift_if           (drift_if),
        .holdoff_active_o   (hold),
        .freq_violation_o   (viol),
        .violation_clear_i  (clr),
        .drifts_in_window_o (drifts)
    );

    // Behavioural model: phase described by flags, pending pulse as a signed direction.
    bit m_active, m_armed, m_viol;
    int m_edges, m_win, m_drifts, m_pulse;

    always @(posedge clk) begin
        bit roll;
        bit n_active, n_armed, n_viol;
        int post, n_win, n_drifts, n_edges, n_pulse;
        if (rst) begin
            m_active = 0; m_armed = 0; m_viol = 0;
            m_edges = 0; m_win = 0; m_drifts = 0; m_pulse = 0;
        end else begin
            roll     = m_active && edg && (((m_win + 1) % 256) == int'(win_e));
            post     = roll ? 1 : (m_drifts < 255 ? m_drifts + 1 : 255);
            n_win    = !m_active ? 0 : roll ? 0 : (m_win + int'(edg)) % 256;
            n_drifts = (m_pulse != 0) ? post : roll ? 0 : m_drifts;
            n_viol   = m_viol;
            if (m_pulse != 0 && win_e != 0 && post > int'(max_d)) n_viol = 1;
            else if (clr) n_viol = 0;
            n_active = m_active; n_armed = m_armed; n_edges = m_edges; n_pulse = 0;
            if (!en) begin
                n_active = 0; n_armed = 0; n_edges = 0; n_win = 0; n_drifts = 0;
            end else if (!m_active) begin
                n_active = 1; n_armed = 0; n_edges = 0;
            end else if (m_pulse != 0) begin
                n_armed = 0; n_edges = int'(edg);
            end else if (!m_armed) begin
                if (m_edges >= int'(min_e)) n_armed = 1;
                n_edges = (m_edges + int'(edg) > 255) ? 255 : m_edges + int'(edg);
            end else if (prdy && (pos != neg)) begin
                n_pulse = pos ? 1 : -1;
                n_armed = 0;
            end
            m_active = n_active; m_armed = n_armed; m_viol = n_viol;
            m_edges = n_edges; m_win = n_win; m_drifts = n_drifts; m_pulse = n_pulse;
        end
    end

    function automatic int dut_vec();
        return {19'd0, drift_if.apply_pos_o, drift_if.apply_neg_o, drift_if.drift_accepted_o,
                hold, viol, drifts};
    endfunction

    function automatic int model_vec();
        bit m_hold;
        m_hold = m_active && !m_armed && (m_pulse == 0);
        return {19'd0, m_pulse == 1, m_pulse == -1, m_pulse != 0, m_hold, m_viol, 8'(m_drifts)};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("model", dut_vec(), model_vec());
        chk("apply_exclusive", int'(drift_if.apply_pos_o & drift_if.apply_neg_o), 0);
    endtask

    task automatic setcfg(input int mn, input int wn, input int mx);
        min_e = 8'(mn); win_e = 8'(wn); max_d = 8'(mx);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b1; edg = 1'b0; clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    typedef struct {
        bit rst, en, edg, pos, prdy;
        int ap, acc, hold, drifts;
    } vec_t;

    vec_t tbl[$];

    initial begin
        rst = 1'b1; en = 1'b1; edg = 1'b0; pos = 1'b0; neg = 1'b0; prdy = 1'b0; clr = 1'b0;
        setcfg(3, 0, 0);

        // rst en edg pos prdy | ap acc hold drifts
        tbl.push_back('{1, 1, 0, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 1, 1, 0, 0, 1, 0});
        tbl.push_back('{0, 1, 1, 1, 1, 0, 0, 1, 0});
        tbl.push_back('{0, 1, 1, 1, 1, 0, 0, 1, 0});
        tbl.push_back('{0, 1, 1, 1, 1, 0, 0, 1, 0});
        tbl.push_back('{0, 1, 0, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 1, 1, 1, 1, 0, 0});
        tbl.push_back('{0, 1, 0, 1, 1, 0, 0, 1, 1});
        tbl.push_back('{0, 1, 1, 1, 1, 0, 0, 1, 1});
        tbl.push_back('{0, 1, 1, 1, 1, 0, 0, 1, 1});
        tbl.push_back('{0, 1, 0, 1, 1, 0, 0, 1, 1});
        tbl.push_back('{0, 1, 1, 1, 1, 0, 0, 1, 1});
        tbl.push_back('{0, 1, 0, 1, 1, 0, 0, 0, 1});
        tbl.push_back('{0, 1, 0, 1, 1, 1, 1, 0, 1});
        tbl.push_back('{0, 1, 0, 1, 1, 0, 0, 1, 2});

        foreach (tbl[i]) begin
            rst = tbl[i].rst; en = tbl[i].en; edg = tbl[i].edg;
            pos = tbl[i].pos; prdy = tbl[i].prdy;
            tick();
            chk("tbl_apply_pos", int'(drift_if.apply_pos_o), tbl[i].ap);
            chk("tbl_accepted", int'(drift_if.drift_accepted_o), tbl[i].acc);
            chk("tbl_holdoff", int'(hold), tbl[i].hold);
            chk("tbl_drifts", int'(drifts), tbl[i].drifts);
        end

        // Preempt stall then illegal both-ready state.
        setcfg(0, 0, 0); pos = 0; neg = 1; prdy = 0;
        do_reset();
        for (int c = 1; c <= 13; c++) begin
            prdy = (c >= 7); pos = (c >= 10);
            tick();
            if (c >= 2 && c <= 6) begin
                chk("stall_no_pulse", int'(drift_if.apply_neg_o), 0);
                chk("stall_armed", int'(hold), 0);
            end
            if (c == 7) begin
                chk("stall_apply_neg", int'(drift_if.apply_neg_o), 1);
                chk("stall_apply_pos", int'(drift_if.apply_pos_o), 0);
                chk("stall_accepted", int'(drift_if.drift_accepted_o), 1);
            end
            if (c == 8) begin
                chk("stall_single_pulse", int'(drift_if.apply_neg_o), 0);
                chk("stall_back_holdoff", int'(hold), 1);
            end
            if (c >= 10) begin
                chk("both_ready_no_accept", int'(drift_if.drift_accepted_o), 0);
                chk("both_ready_stay_armed", int'(hold), 0);
            end
        end

        // Frequency violation: one edge per apply, set beats concurrent clear.
        setcfg(1, 8, 2); pos = 1; neg = 0; prdy = 1;
        do_reset();
        for (int c = 1; c <= 11; c++) begin
            edg = (c % 3 == 1); clr = (c == 10) || (c == 11);
            tick();
            if (c == 7) begin
                chk("win_drifts_2", int'(drifts), 2);
                chk("win_no_viol_yet", int'(viol), 0);
            end
            if (c == 9) chk("win_third_apply", int'(drift_if.apply_pos_o), 1);
            if (c == 10) begin
                chk("win_drifts_3", int'(drifts), 3);
                chk("win_viol_set_beats_clear", int'(viol), 1);
            end
            if (c == 11) chk("win_viol_cleared", int'(viol), 0);
        end
        clr = 0;

        // APPLY coincident with window rollover.
        setcfg(1, 4, 255);
        do_reset();
        for (int c = 1; c <= 11; c++) begin
            edg = (c % 3 == 1);
            tick();
            if (c == 7) chk("roll_drifts_before", int'(drifts), 2);
            if (c == 9) chk("roll_apply", int'(drift_if.apply_pos_o), 1);
            if (c == 10) begin
                chk("roll_drifts_new_window", int'(drifts), 1);
                chk("roll_holdoff", int'(hold), 1);
            end
            if (c == 11) chk("roll_holdoff_cnt_one", int'(hold), 0);
        end

        // Disable while ARMED with the apply condition met.
        setcfg(0, 8, 0); edg = 0;
        do_reset();
        for (int c = 1; c <= 6; c++) begin
            en = (c < 5);
            tick();
            if (c == 2) chk("dis_apply", int'(drift_if.apply_pos_o), 1);
            if (c == 3) chk("dis_viol_set", int'(viol), 1);
            if (c == 4) chk("dis_armed", int'(hold), 0);
            if (c >= 5) begin
                chk("dis_no_pulse", int'(drift_if.drift_accepted_o), 0);
                chk("dis_no_holdoff", int'(hold), 0);
                chk("dis_drifts_zero", int'(drifts), 0);
                chk("dis_viol_kept", int'(viol), 1);
            end
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) < 3) begin
                min_e = 8'($urandom_range(0, 4));
                win_e = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(3, 12));
                max_d = 8'($urandom_range(0, 4));
            end
            rst  = ($urandom_range(0, 499) == 0);
            en   = ($urandom_range(0, 49) != 0);
            edg  = ($urandom_range(0, 1) == 1);
            pos  = ($urandom_range(0, 3) != 0);
            neg  = ($urandom_range(0, 3) == 0);
            prdy = ($urandom_range(0, 2) != 0);
            clr  = ($urandom_range(0, 19) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
